// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx_in, validates the start bit, samples data LSB first
// at mid-bit and checks the stop bit, emitting a one-cycle strobe per good frame.
module uart_rx #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_in,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_out_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
    logic                rx_s;

    assign rx_s           = sync2_q;
    assign word_out       = word_q;
    assign word_out_valid = valid_q;
    assign frame_err      = ferr_q;
    assign busy           = busy_q;

    // Next-state logic: frame FSM, bit-cycle counter and result strobes.
    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ZERO;
                    // A line that is high again at mid start bit was only a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = CNT_ZERO;
                    // Leaving at mid stop bit lets a back-to-back start bit be caught.
                    if (rx_s) begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = CNT_ZERO;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shift_q <= {NUM_BITS{1'b0}};
            word_q  <= {NUM_BITS{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that turns the asynchronous MIDI/serial input pin into parallel bytes for the synth's receive path. It synchronizes the line, detects and validates start bits, samples data bits at mid-bit (LSB first), and checks the stop bit. Each good frame produces a one-cycle write strobe whose data and strobe connect directly to the receive FIFO's write port (`word_in` / `word_in_valid`).

## Interface
- `NUM_BITS`, default 8: data bits per frame.
- `CLKS_PER_BIT`, default 3200: clk cycles per bit (100 MHz / 31250 baud). Legal range is 4 or more.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: synchronous, active-low reset; clock clk.
- `rx_in`, input, 1: asynchronous serial line. Idles high.
- `word_out`, output, NUM_BITS: last correctly framed byte. Bit 0 is the first data bit received.
- `word_out_valid`, output, 1: one-cycle pulse when `word_out` is updated. Drives the FIFO `word_in_valid`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- **Input synchronizer.** `rx_in` passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value, called `rx_s` below.
- **Bit-cycle counter.** Width is $clog2(CLKS_PER_BIT). It is cleared on every state change and whenever a sample is taken.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE.** When `rx_s` is 0, go to START with the counter at 0.
- **START.** When count reaches CLKS_PER_BIT/2−1 (integer division), sample `rx_s`:
  - 0: go to DATA, bit index = 0.
  - 1: false start (glitch). Go to IDLE with no output.
- **DATA.** When count reaches CLKS_PER_BIT−1, sample `rx_s` into the shift register at position bit index (LSB first), then increment bit index. After sample NUM_BITS−1, go to STOP.
- **STOP.** When count reaches CLKS_PER_BIT−1, sample `rx_s`:
  - 1: load `word_out` from the shift register, pulse `word_out_valid`, go to IDLE.
  - 0: pulse `frame_err`, leave `word_out` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` is 1, then go to IDLE. A break condition or stuck-low line produces exactly one `frame_err` and no repeated start detections.
- **Early return to IDLE.** The block returns to IDLE at the middle of the stop bit. A start bit arriving immediately after the stop bit is therefore caught, so back-to-back frames need no idle gap.
- **No handshake.** There is no backpressure. A full downstream FIFO drops the byte; that is the FIFO's policy, not this block's.
- **Reset.** Reset at any point, including mid-frame, forces:
  - state IDLE, counter 0, bit index 0, shift register 0;
  - synchronizer flops to 1;
  - `word_out` = 0, `word_out_valid` = 0, `frame_err` = 0, `busy` = 0.

## Timing
- **T0** is the first clk edge at which IDLE sees `rx_s` = 0. This is 2–3 cycles after the falling edge at the pin, due to the synchronizer.
- **Start sample** occurs at T0 + CLKS_PER_BIT/2.
- **Data bit i** (i = 0 … NUM_BITS−1) is sampled at T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- **Stop sample** occurs at T0 + CLKS_PER_BIT/2 + (NUM_BITS+1)·CLKS_PER_BIT.
- **Result outputs.** `word_out`, `word_out_valid` or `frame_err` are registered and visible in the cycle after the stop sample, for exactly one cycle.
- **busy.** Rises in the cycle after T0. Falls in the same cycle the result pulse is visible, except after a framing error, where it falls after WAIT_HIGH exits.
- **Exclusivity.** `word_out_valid` and `frame_err` are never high together.
- **Baud tolerance.** Mid-bit sampling tolerates about ±4% accumulated baud mismatch over a 10-bit frame.

## Test plan
All scenarios use CLKS_PER_BIT = 16, NUM_BITS = 8, and the line idles high.

- **Single frame.** Drive a frame carrying 0xA5 with stop = 1. Require `word_out` = 0xA5 and one `word_out_valid` pulse at T0 + 8 + 9·16 + 1. Require `frame_err` to stay 0.
- **Back-to-back frames.** Drive 0x00 and then 0xFF with no idle gap. Require two valid pulses 160 cycles apart carrying 0x00 then 0xFF, and `busy` low for at most 8 cycles between them.
- **Glitch rejection.** Drive `rx_in` low for 4 cycles, then high. Require `busy` to pulse and then return to 0 by T0 + 9, no `word_out_valid`, no `frame_err`, and `word_out` unchanged.
- **Framing error and recovery.**
  - Drive 0x3C with the stop bit low, holding the line low for 40 cycles afterwards. Require one `frame_err` pulse, no valid pulse, `word_out` still holding its prior value, and `busy` high until the line returns high.
  - Then drive 0x81. Require `word_out` = 0x81 with a valid pulse.
- **Reset mid-frame.** Drive a frame and assert `rst_n` = 0 for 2 cycles during data bit 3.
  - Require all outputs to be 0 on the cycle after reset.
  - Require no pulse from the truncated frame once the remaining bits have finished arriving.
  - Then drive 0x5A. Require `word_out` = 0x5A with a valid pulse.
